// File: rtl/ad_acq_pkg.sv
// ---------------------------------------------------------------------------
// ad_acq_pkg
//   Shared definitions for the AD7606 acquisition controller:
//   - FSM state encoding of the controller
//   - read-strobe phase encoding of the bus sequencer
//   - oversampling (OS[2:0]) code constants
//   - FRSTDATA rule constants and the helper that applies them
// ---------------------------------------------------------------------------
package ad_acq_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_IDLE,
      ST_CONV,
      ST_WBH,
      ST_WBL,
      ST_READ,
      ST_DONE
   } acq_state_t;

   typedef enum logic {
      PH_LOW,
      PH_HIGH
   } rd_phase_t;

   // AD7606 oversampling ratio codes
   localparam logic [2:0] OS_NONE = 3'd0;
   localparam logic [2:0] OS_X2   = 3'd1;
   localparam logic [2:0] OS_X4   = 3'd2;
   localparam logic [2:0] OS_X8   = 3'd3;
   localparam logic [2:0] OS_X16  = 3'd4;
   localparam logic [2:0] OS_X32  = 3'd5;
   localparam logic [2:0] OS_X64  = 3'd6;

   // FRSTDATA level expected for the first word of a set and for all others
   localparam logic FIRST_WORD0 = 1'b1;
   localparam logic FIRST_OTHER = 1'b0;

   function automatic logic first_ok(input logic is_word0, input logic first);
      return first == (is_word0 ? FIRST_WORD0 : FIRST_OTHER);
   endfunction

endpackage

// File: rtl/ad_rd_sequencer.sv
// ---------------------------------------------------------------------------
// ad_rd_sequencer
//   Parallel-bus read sequencer: on i_start pulls CS low and issues CHN_NUM
//   read strobes (RD low RD_LOW cycles, high RD_HIGH cycles). Data and
//   FRSTDATA are latched on the last low cycle of each strobe.
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   i_start         start a read of all channels (one-cycle pulse)
//   i_abort         drop CS/RD immediately, suppress the rest of the set
//   i_data/i_first  ADC data bus and FRSTDATA
//   o_cs_n/o_rd_n   chip select / read strobe, active low
//   o_word_vd       one-cycle pulse, the cycle after a word is latched
//   o_word_chn      channel index of the latched word
//   o_word_data     latched data
//   o_word_first    latched FRSTDATA
//   o_done          one-cycle pulse after the last strobe, CS released
// ---------------------------------------------------------------------------
module ad_rd_sequencer
   import ad_acq_pkg::*;
#(
   parameter int unsigned DATA_NBIT = 16,
   parameter int unsigned CHN_NUM   = 8,
   parameter int unsigned CHN_NBIT  = 3,
   parameter int unsigned RD_LOW    = 3,
   parameter int unsigned RD_HIGH   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [DATA_NBIT-1:0] i_data,
   input  logic                 i_first,
   output logic                 o_cs_n,
   output logic                 o_rd_n,
   output logic                 o_word_vd,
   output logic [CHN_NBIT-1:0]  o_word_chn,
   output logic [DATA_NBIT-1:0] o_word_data,
   output logic                 o_word_first,
   output logic                 o_done
);

   localparam int unsigned CNT_MAX = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   logic                 r_active;
   rd_phase_t            r_phase;
   logic [CW-1:0]        r_cnt;
   logic [CHN_NBIT-1:0]  r_chn;
   logic                 r_cs_n;
   logic                 r_rd_n;
   logic                 r_word_vd;
   logic [CHN_NBIT-1:0]  r_word_chn;
   logic [DATA_NBIT-1:0] r_word_data;
   logic                 r_word_first;
   logic                 r_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active     <= 1'b0;
         r_phase      <= PH_LOW;
         r_cnt        <= '0;
         r_chn        <= '0;
         r_cs_n       <= 1'b1;
         r_rd_n       <= 1'b1;
         r_word_vd    <= 1'b0;
         r_word_chn   <= '0;
         r_word_data  <= '0;
         r_word_first <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_word_vd <= 1'b0;
         r_done    <= 1'b0;
         if (i_abort) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
         end else if (i_start) begin
            r_active <= 1'b1;
            r_cs_n   <= 1'b0;
            r_rd_n   <= 1'b0;
            r_phase  <= PH_LOW;
            r_cnt    <= '0;
            r_chn    <= '0;
         end else if (r_active) begin
            if (r_phase == PH_LOW) begin
               if (r_cnt == CW'(RD_LOW - 1)) begin
                  r_word_vd    <= 1'b1;
                  r_word_chn   <= r_chn;
                  r_word_data  <= i_data;
                  r_word_first <= i_first;
                  r_rd_n       <= 1'b1;
                  r_phase      <= PH_HIGH;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end else begin
               if (r_cnt == CW'(RD_HIGH - 1)) begin
                  r_cnt <= '0;
                  if (r_chn == CHN_NBIT'(CHN_NUM - 1)) begin
                     r_active <= 1'b0;
                     r_cs_n   <= 1'b1;
                     r_done   <= 1'b1;
                  end else begin
                     r_chn   <= r_chn + CHN_NBIT'(1);
                     r_rd_n  <= 1'b0;
                     r_phase <= PH_LOW;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
         end
      end
   end

   assign o_cs_n       = r_cs_n;
   assign o_rd_n       = r_rd_n;
   assign o_word_vd    = r_word_vd;
   assign o_word_chn   = r_word_chn;
   assign o_word_data  = r_word_data;
   assign o_word_first = r_word_first;
   assign o_done       = r_done;

endmodule

// File: rtl/ad7606_acq_ctrl.sv
// ---------------------------------------------------------------------------
// ad7606_acq_ctrl
//   AD7606-family acquisition controller. Paces conversions from
//   conv_period, reads all CHN_NUM results over the parallel bus and emits
//   the mask-enabled channels as a {chn,data} stream. Checks FRSTDATA
//   framing, times out on a missing BUSY edge, drives OS pins, and stops
//   gracefully when en drops (the current set always completes).
// Ports
//   clk, rst_n       ADC clock, synchronous active-low reset
//   en               acquisition enable
//   conv_period      clk cycles between CONVST rising edges (0 acts as 1)
//   os_cfg / ad_os   oversampling code in / registered to ADC
//   chn_mask         1 = emit channel (captured at each conversion start)
//   ad_data          ADC parallel data
//   ad_busy          ADC BUSY (asynchronous, synchronised here)
//   ad_first         ADC FRSTDATA
//   ad_cs, ad_rd     chip select / read strobe, active low
//   ad_reset         ADC reset, active high
//   ad_convst        CONVST, conversion starts on rising edge
//   out_vd/chn/data  output stream, out_sof marks lowest enabled channel
//   sync_err         sticky FRSTDATA mismatch
//   tmo_err          sticky BUSY timeout
//   set_cnt          wrapping count of completed sample sets
// ---------------------------------------------------------------------------
module ad7606_acq_ctrl
   import ad_acq_pkg::*;
#(
   parameter int unsigned DATA_NBIT   = 16,
   parameter int unsigned CHN_NUM     = 8,
   parameter int unsigned CHN_NBIT    = 3,
   parameter int unsigned PERIOD_NBIT = 16,
   parameter int unsigned RD_LOW      = 3,
   parameter int unsigned RD_HIGH     = 2,
   parameter int unsigned RST_CYC     = 5,
   parameter int unsigned BUSY_TMO    = 400
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [PERIOD_NBIT-1:0] conv_period,
   input  logic [2:0]             os_cfg,
   input  logic [CHN_NUM-1:0]     chn_mask,
   input  logic [DATA_NBIT-1:0]   ad_data,
   input  logic                   ad_busy,
   input  logic                   ad_first,
   output logic [2:0]             ad_os,
   output logic                   ad_cs,
   output logic                   ad_rd,
   output logic                   ad_reset,
   output logic                   ad_convst,
   output logic                   out_vd,
   output logic [CHN_NBIT-1:0]    out_chn,
   output logic [DATA_NBIT-1:0]   out_data,
   output logic                   out_sof,
   output logic                   sync_err,
   output logic                   tmo_err,
   output logic [15:0]            set_cnt
);

   localparam int unsigned CNT_MAX0 = (BUSY_TMO > RST_CYC) ? BUSY_TMO : RST_CYC;
   localparam int unsigned CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   acq_state_t             r_state;
   acq_state_t             w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [PERIOD_NBIT-1:0] r_per_cnt;
   logic                   r_armed;
   logic [CHN_NUM-1:0]     r_mask;
   logic                   r_busy_s1;
   logic                   r_busy_s2;
   logic [2:0]             r_ad_os;
   logic                   r_ad_reset;
   logic                   r_ad_convst;
   logic                   r_sync_err;
   logic                   r_tmo_err;
   logic [15:0]            r_set_cnt;

   logic [PERIOD_NBIT-1:0] w_period_m1;
   logic                   w_per_exp;
   logic                   w_tmo;
   logic                   w_sync_fail;
   logic                   w_seq_start;
   logic                   w_seq_abort;
   logic                   w_word_vd;
   logic [CHN_NBIT-1:0]    w_word_chn;
   logic [DATA_NBIT-1:0]   w_word_data;
   logic                   w_word_first;
   logic                   w_word_ok;
   logic                   w_first_bad;
   logic                   w_seq_done;
   logic                   w_mask_hit;
   logic [CHN_NBIT-1:0]    w_low_chn;
   logic                   w_low_found;
   logic                   w_convst_nxt;
   logic                   w_reset_nxt;
   logic                   w_cs_n;
   logic                   w_rd_n;

   ad_rd_sequencer #(
      .DATA_NBIT (DATA_NBIT),
      .CHN_NUM   (CHN_NUM),
      .CHN_NBIT  (CHN_NBIT),
      .RD_LOW    (RD_LOW),
      .RD_HIGH   (RD_HIGH)
   ) u_seq (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (w_seq_start),
      .i_abort      (w_seq_abort),
      .i_data       (ad_data),
      .i_first      (ad_first),
      .o_cs_n       (w_cs_n),
      .o_rd_n       (w_rd_n),
      .o_word_vd    (w_word_vd),
      .o_word_chn   (w_word_chn),
      .o_word_data  (w_word_data),
      .o_word_first (w_word_first),
      .o_done       (w_seq_done)
   );

   assign w_period_m1 = (conv_period == '0) ? '0 : conv_period - PERIOD_NBIT'(1);
   assign w_per_exp   = (r_per_cnt >= w_period_m1);
   assign w_word_ok   = first_ok(w_word_chn == '0, w_word_first);
   assign w_first_bad = w_word_vd && !w_word_ok;

   // ---- state register ---------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_RST;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---- next-state logic -------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_tmo       = 1'b0;
      w_sync_fail = 1'b0;
      case (r_state)
         // r_cnt only advances while ad_reset is actually high, so the pulse
         // is RST_CYC cycles both after rst_n and after an error.
         ST_RST: begin
            if (r_ad_reset && (r_cnt == CNT_W'(RST_CYC - 1))) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (en && (!r_armed || w_per_exp)) begin
               w_state_nxt = ST_CONV;
            end
         end
         ST_CONV: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_WBH;
            end
         end
         ST_WBH: begin
            if (r_busy_s2) begin
               w_state_nxt = ST_WBL;
            end else if (r_cnt == CNT_W'(BUSY_TMO - 1)) begin
               w_state_nxt = ST_RST;
               w_tmo       = 1'b1;
            end
         end
         ST_WBL: begin
            if (!r_busy_s2) begin
               w_state_nxt = ST_READ;
            end else if (r_cnt == CNT_W'(BUSY_TMO - 1)) begin
               w_state_nxt = ST_RST;
               w_tmo       = 1'b1;
            end
         end
         ST_READ: begin
            if (w_first_bad) begin
               w_state_nxt = ST_RST;
               w_sync_fail = 1'b1;
            end else if (w_seq_done) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_RST;
         end
      endcase
   end

   // ---- output logic -----------------------------------------------------
   always_comb begin
      w_seq_start  = (r_state == ST_WBL)  && (w_state_nxt == ST_READ);
      w_seq_abort  = (r_state == ST_READ) && (w_state_nxt == ST_RST);
      // pin registers follow the next state so pins line up with the state
      w_convst_nxt = (w_state_nxt != ST_CONV);
      w_reset_nxt  = (w_state_nxt == ST_RST);

      w_mask_hit  = 1'b0;
      w_low_chn   = '0;
      w_low_found = 1'b0;
      for (int unsigned k = 0; k < CHN_NUM; k++) begin
         if (w_word_chn == CHN_NBIT'(k)) begin
            w_mask_hit = r_mask[k];
         end
         if (!w_low_found && r_mask[k]) begin
            w_low_chn   = CHN_NBIT'(k);
            w_low_found = 1'b1;
         end
      end

      out_vd   = w_word_vd && w_word_ok && w_mask_hit && (r_state == ST_READ);
      out_sof  = out_vd && (w_word_chn == w_low_chn);
      out_chn  = w_word_chn;
      out_data = w_word_data;
   end

   // ---- counters, timer, registered pins and status ----------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_per_cnt   <= '0;
         r_armed     <= 1'b0;
         r_mask      <= '0;
         r_busy_s1   <= 1'b0;
         r_busy_s2   <= 1'b0;
         r_ad_os     <= OS_NONE;
         r_ad_reset  <= 1'b0;
         r_ad_convst <= 1'b1;
         r_sync_err  <= 1'b0;
         r_tmo_err   <= 1'b0;
         r_set_cnt   <= '0;
      end else begin
         r_busy_s1   <= ad_busy;
         r_busy_s2   <= r_busy_s1;
         r_ad_os     <= os_cfg;
         r_ad_reset  <= w_reset_nxt;
         r_ad_convst <= w_convst_nxt;

         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if ((r_state != ST_RST) || r_ad_reset) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // period timer restarts at every conversion start and saturates
         if ((r_state != ST_CONV) && (w_state_nxt == ST_CONV)) begin
            r_per_cnt <= '0;
            r_armed   <= 1'b1;
            r_mask    <= chn_mask;
         end else if (((r_state == ST_IDLE) && !en) || (r_state == ST_RST)) begin
            r_per_cnt <= '0;
            r_armed   <= 1'b0;
         end else if (r_per_cnt != '1) begin
            r_per_cnt <= r_per_cnt + PERIOD_NBIT'(1);
         end

         if (w_tmo) begin
            r_tmo_err <= 1'b1;
         end
         if (w_sync_fail) begin
            r_sync_err <= 1'b1;
         end
         if (r_state == ST_DONE) begin
            r_set_cnt <= r_set_cnt + 16'd1;
         end
      end
   end

   assign ad_os     = r_ad_os;
   assign ad_cs     = w_cs_n;
   assign ad_rd     = w_rd_n;
   assign ad_reset  = r_ad_reset;
   assign ad_convst = r_ad_convst;
   assign sync_err  = r_sync_err;
   assign tmo_err   = r_tmo_err;
   assign set_cnt   = r_set_cnt;

endmodule

// File: tb/tb_ad7606_acq_ctrl.sv
module tb_ad7606_acq_ctrl;

   localparam int BUSY_TMO = 400;
   localparam int RST_CYC  = 5;
   localparam int BUSY_LEN = 80;

   typedef struct packed {
      logic        sof;
      logic [2:0]  chn;
      logic [15:0] data;
      logic [3:0]  mset;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] conv_period;
   logic [2:0]  os_cfg;
   logic [7:0]  chn_mask;
   logic [15:0] ad_data;
   logic        ad_busy;
   logic        ad_first;
   logic [2:0]  ad_os;
   logic        ad_cs;
   logic        ad_rd;
   logic        ad_reset;
   logic        ad_convst;
   logic        out_vd;
   logic [2:0]  out_chn;
   logic [15:0] out_data;
   logic        out_sof;
   logic        sync_err;
   logic        tmo_err;
   logic [15:0] set_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clk = ~clk;

   ad7606_acq_ctrl #(
      .DATA_NBIT   (16),
      .CHN_NUM     (8),
      .CHN_NBIT    (3),
      .PERIOD_NBIT (16),
      .RD_LOW      (3),
      .RD_HIGH     (2),
      .RST_CYC     (RST_CYC),
      .BUSY_TMO    (BUSY_TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .conv_period (conv_period),
      .os_cfg      (os_cfg),
      .chn_mask    (chn_mask),
      .ad_data     (ad_data),
      .ad_busy     (ad_busy),
      .ad_first    (ad_first),
      .ad_os       (ad_os),
      .ad_cs       (ad_cs),
      .ad_rd       (ad_rd),
      .ad_reset    (ad_reset),
      .ad_convst   (ad_convst),
      .out_vd      (out_vd),
      .out_chn     (out_chn),
      .out_data    (out_data),
      .out_sof     (out_sof),
      .sync_err    (sync_err),
      .tmo_err     (tmo_err),
      .set_cnt     (set_cnt)
   );

   // ---- ADC model ----------------------------------------------------------
   logic       stuck = 1'b0;
   logic       fault = 1'b0;
   logic       m_conv_prev = 1'b1;
   logic       m_busy = 1'b0;
   int         m_bcnt = 0;
   logic [3:0] mset = 4'd0;
   logic [3:0] widx = 4'd0;
   logic       m_rd_prev = 1'b1;

   always @(posedge clk) begin
      m_conv_prev <= ad_convst;
      if (!m_conv_prev && ad_convst) begin
         mset <= mset + 4'd1;
         if (!stuck) begin
            m_busy <= 1'b1;
            m_bcnt <= BUSY_LEN;
         end
      end else if (m_bcnt != 0) begin
         m_bcnt <= m_bcnt - 1;
         if (m_bcnt == 1) m_busy <= 1'b0;
      end
      m_rd_prev <= ad_rd;
      if (ad_cs) widx <= 4'd0;
      else if (!m_rd_prev && ad_rd) widx <= widx + 4'd1;
   end

   assign ad_busy  = m_busy;
   assign ad_data  = {4'hA, mset, 4'h0, widx};
   assign ad_first = !ad_cs && ((widx == 4'd0) || (fault && widx == 4'd3));

   // ---- output monitor -----------------------------------------------------
   ent_t q[$];
   int   rise_q[$];
   int   cyc = 0;
   int   rd_falls = 0;
   logic mon_conv_prev = 1'b1;
   logic mon_rd_prev = 1'b1;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (out_vd) q.push_back({out_sof, out_chn, out_data, mset});
      if (!mon_conv_prev && ad_convst) rise_q.push_back(cyc);
      if (mon_rd_prev && !ad_rd) rd_falls = rd_falls + 1;
      mon_conv_prev = ad_convst;
      mon_rd_prev   = ad_rd;
   end

   task automatic wait_set(input logic [15:0] target, input int budget, output bit ok);
      int n = 0;
      while (set_cnt !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (set_cnt === target);
   endtask

   // ---- tests --------------------------------------------------------------
   task automatic test_reset();
      int hi = 0;
      bit seen = 0;
      rst_n = 1'b0; en = 1'b0; conv_period = 16'd1000; os_cfg = 3'b000; chn_mask = 8'hFF;
      repeat (3) @(negedge clk);
      os_cfg = 3'b101;
      @(negedge clk);
      n_tests++;
      if ({ad_cs, ad_rd, ad_convst, ad_reset, out_vd, out_sof, sync_err, tmo_err} !== 8'b1110_0000) begin
         n_fail++;
         $display("FAIL reset_pins got %b want 11100000", {ad_cs, ad_rd, ad_convst, ad_reset, out_vd, out_sof, sync_err, tmo_err});
      end
      n_tests++;
      if ({ad_os, out_chn, out_data, set_cnt} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_values got os=%0d chn=%0d data=%h set=%0d want all 0", ad_os, out_chn, out_data, set_cnt);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ad_reset === 1'b1) begin hi++; seen = 1; end
         else if (seen) break;
      end
      n_tests++;
      if (hi != RST_CYC) begin
         n_fail++;
         $display("FAIL ad_reset_width got %0d want %0d", hi, RST_CYC);
      end
      n_tests++;
      if (ad_os !== 3'b101) begin
         n_fail++;
         $display("FAIL ad_os got %b want 101", ad_os);
      end
   endtask

   task automatic test_full_mask();
      int base = q.size();
      int rb = rise_q.size();
      int rd0 = rd_falls;
      bit ok;
      logic [15:0] exp_d;
      logic [3:0] kk;
      en = 1'b1;
      wait_set(16'd2, 4000, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL full_sets set_cnt=%0d want 2", set_cnt); end
      n_tests++;
      if (q.size() - base != 16) begin
         n_fail++; $display("FAIL full_count got %0d want 16", q.size() - base);
      end else begin
         for (int i = 0; i < 16; i++) begin
            kk = 4'(i % 8);
            exp_d = {4'hA, q[base+i].mset, 4'h0, kk};
            n_tests++;
            if (q[base+i].chn !== kk[2:0] || q[base+i].sof !== (kk == 4'd0) || q[base+i].data !== exp_d) begin
               n_fail++;
               $display("FAIL full_word%0d got chn=%0d sof=%b data=%h want chn=%0d sof=%b data=%h",
                        i, q[base+i].chn, q[base+i].sof, q[base+i].data, kk, (kk == 4'd0), exp_d);
            end
         end
      end
      n_tests++;
      if (rise_q.size() - rb < 2 || rise_q[rb+1] - rise_q[rb] != 1000) begin
         n_fail++; $display("FAIL convst_spacing got %0d want 1000",
                            (rise_q.size() - rb >= 2) ? rise_q[rb+1] - rise_q[rb] : -1);
      end
      n_tests++;
      if (rd_falls - rd0 != 16) begin
         n_fail++; $display("FAIL full_rd_pulses got %0d want 16", rd_falls - rd0);
      end
   endtask

   task automatic test_mask();
      int base = q.size();
      int rd0 = rd_falls;
      int exp_c[3] = '{2, 5, 7};
      bit ok;
      chn_mask = 8'b1010_0100;
      wait_set(16'd3, 1500, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL mask_set set_cnt=%0d want 3", set_cnt); end
      n_tests++;
      if (q.size() - base != 3) begin
         n_fail++; $display("FAIL mask_count got %0d want 3", q.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (q[base+i].chn !== 3'(exp_c[i]) || q[base+i].sof !== (i == 0) || q[base+i].data[3:0] !== 4'(exp_c[i])) begin
               n_fail++;
               $display("FAIL mask_word%0d got chn=%0d sof=%b data=%h want chn=%0d sof=%b",
                        i, q[base+i].chn, q[base+i].sof, q[base+i].data, exp_c[i], (i == 0));
            end
         end
      end
      n_tests++;
      if (rd_falls - rd0 != 8) begin
         n_fail++; $display("FAIL mask_rd_pulses got %0d want 8", rd_falls - rd0);
      end
   endtask

   task automatic test_sync_err();
      int base = q.size();
      int n = 0;
      bit ok;
      chn_mask = 8'hFF;
      fault = 1'b1;
      while (sync_err !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
      n_tests++;
      if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_set got %b want 1", sync_err); end
      n_tests++;
      if (ad_reset !== 1'b1) begin n_fail++; $display("FAIL sync_reset_pulse got %b want 1", ad_reset); end
      repeat (10) @(negedge clk);
      n_tests++;
      if (q.size() - base != 3) begin
         n_fail++; $display("FAIL sync_emitted got %0d want 3", q.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (q[base+i].chn !== 3'(i)) begin
               n_fail++; $display("FAIL sync_word%0d got chn=%0d want %0d", i, q[base+i].chn, i);
            end
         end
      end
      n_tests++;
      if (set_cnt !== 16'd3) begin n_fail++; $display("FAIL sync_set_cnt got %0d want 3", set_cnt); end
      fault = 1'b0;
      wait_set(16'd4, 2000, ok);
      n_tests++;
      if (!ok || q.size() - base != 11) begin
         n_fail++; $display("FAIL sync_recover got set=%0d words=%0d want set=4 words=11", set_cnt, q.size() - base);
      end
      n_tests++;
      if ({sync_err, tmo_err} !== 2'b10) begin
         n_fail++; $display("FAIL sync_sticky got %b want 10", {sync_err, tmo_err});
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      bit ok;
      stuck = 1'b1;
      while (ad_convst !== 1'b0 && n < 1500) begin @(negedge clk); n++; end
      n = 0;
      while (ad_convst !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (tmo_err !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      n_tests++;
      if (n != BUSY_TMO) begin n_fail++; $display("FAIL tmo_latency got %0d want %0d", n, BUSY_TMO); end
      n_tests++;
      if ({tmo_err, ad_reset, ad_cs} !== 3'b111) begin
         n_fail++; $display("FAIL tmo_rst got %b want 111", {tmo_err, ad_reset, ad_cs});
      end
      n_tests++;
      if (set_cnt !== 16'd4) begin n_fail++; $display("FAIL tmo_set_cnt got %0d want 4", set_cnt); end
      stuck = 1'b0;
      wait_set(16'd5, 2000, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL tmo_recover set_cnt=%0d want 5", set_cnt); end
   endtask

   task automatic test_en_drop();
      int base;
      int rb;
      int n = 0;
      bit ok;
      while (!(ad_cs === 1'b0 && widx == 4'd4) && n < 1500) begin @(negedge clk); n++; end
      base = q.size();
      en = 1'b0;
      wait_set(16'd6, 500, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL endrop_set set_cnt=%0d want 6", set_cnt); end
      n_tests++;
      if (q.size() - base != 4) begin
         n_fail++; $display("FAIL endrop_count got %0d want 4", q.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (q[base+i].chn !== 3'(i + 4)) begin
               n_fail++; $display("FAIL endrop_word%0d got chn=%0d want %0d", i, q[base+i].chn, i + 4);
            end
         end
      end
      rb = rise_q.size();
      repeat (2500) @(negedge clk);
      n_tests++;
      if (rise_q.size() != rb || set_cnt !== 16'd6) begin
         n_fail++; $display("FAIL endrop_idle got rises=%0d set=%0d want rises=0 set=6", rise_q.size() - rb, set_cnt);
      end
   endtask

   task automatic test_rst_mid();
      int n = 0;
      bit ok;
      en = 1'b1;
      while (ad_busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      n_tests++;
      if (ad_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got %b want 1", ad_busy); end
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({ad_cs, ad_rd, ad_convst, ad_reset, out_vd, out_sof, sync_err, tmo_err} !== 8'b1110_0000) begin
         n_fail++;
         $display("FAIL rstmid_pins got %b want 11100000", {ad_cs, ad_rd, ad_convst, ad_reset, out_vd, out_sof, sync_err, tmo_err});
      end
      n_tests++;
      if ({ad_os, out_chn, out_data, set_cnt} !== 38'd0) begin
         n_fail++;
         $display("FAIL rstmid_values got os=%0d chn=%0d data=%h set=%0d want all 0", ad_os, out_chn, out_data, set_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_set(16'd1, 3000, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_recover set_cnt=%0d want 1", set_cnt); end
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_mask();
      test_sync_err();
      test_timeout();
      test_en_drop();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
